// File: rtl/ks_round_sched.sv
//==============================================================================
// Module  : ks_round_sched
// Brief   : Round sequencer for the N-channel time-interleaved AES key schedule.
//           Define KS_SCHED_STATS_EN to add the sched_cnt completion counter.
// Revision: 1.0
//==============================================================================
`default_nettype none

module ks_round_sched #(
    parameter int N  = 4,
    parameter int CW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic [N-1:0]  start,
    input  logic [N-1:0]  abort,
    output logic [N-1:0]  start_ack,
    output logic [3:0]    rnd_no,
    output logic          ena_ks,
    output logic [CW-1:0] key_sel,
    output logic [CW-1:0] slot_id,
    output logic          rk_valid,
    output logic          rk_last,
    output logic [N-1:0]  ch_busy,
    output logic [N-1:0]  ch_done
`ifdef KS_SCHED_STATS_EN
    ,
    output logic [15:0]   sched_cnt
`endif
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } ch_state_e;

    localparam logic [3:0]    c_LAST_RND = 4'd10;
    localparam logic [CW-1:0] c_SLOT_MAX = CW'(N - 1);

    logic [CW-1:0] slot_q;
    logic [CW-1:0] slot_d;
    ch_state_e     st_q  [N];
    ch_state_e     st_d  [N];
    logic [3:0]    rnd_q [N];
    logic [3:0]    rnd_d [N];
    logic [N-1:0]  done_q;
    logic [N-1:0]  done_d;

    ch_state_e     w_own_st;
    logic [3:0]    w_own_rnd;
    logic          w_own_abort;
    logic          w_own_start;

    // The slot walks the channels in lock-step with the key pipeline and never stalls.
    assign slot_d      = (slot_q == c_SLOT_MAX) ? '0 : slot_q + CW'(1);
    assign w_own_st    = st_q[slot_q];
    assign w_own_rnd   = rnd_q[slot_q];
    assign w_own_abort = abort[slot_q];
    assign w_own_start = start[slot_q] & rstn;

    assign slot_id = slot_q;
    assign key_sel = slot_q;
    assign ch_done = done_q;

    for (genvar c = 0; c < N; c++) begin : g_busy
        assign ch_busy[c] = (st_q[c] == ST_RUN);
    end

    always_comb begin
        for (int c = 0; c < N; c++) begin
            st_d[c]  = st_q[c];
            rnd_d[c] = rnd_q[c];
        end
        done_d    = '0;
        start_ack = '0;
        rnd_no    = 4'd0;
        ena_ks    = 1'b0;
        rk_valid  = 1'b0;
        rk_last   = 1'b0;

        for (int c = 0; c < N; c++) begin
            if (abort[c]) begin
                st_d[c]  = ST_IDLE;
                rnd_d[c] = 4'd0;
            end
        end

        if (!w_own_abort) begin
            if (w_own_st == ST_IDLE) begin
                if (w_own_start) begin
                    // Round 0 key is the cipher key itself, emitted on acceptance.
                    start_ack[slot_q] = 1'b1;
                    ena_ks            = 1'b1;
                    rk_valid          = 1'b1;
                    st_d[slot_q]      = ST_RUN;
                    rnd_d[slot_q]     = 4'd1;
                end
            end else if (w_own_rnd <= c_LAST_RND) begin
                rnd_no   = w_own_rnd;
                ena_ks   = 1'b1;
                rk_valid = 1'b1;
                if (w_own_rnd == c_LAST_RND) begin
                    rk_last        = 1'b1;
                    st_d[slot_q]   = ST_IDLE;
                    rnd_d[slot_q]  = 4'd0;
                    done_d[slot_q] = 1'b1;
                end else begin
                    rnd_d[slot_q] = w_own_rnd + 4'd1;
                end
            end else begin
                // A corrupted round count is recovered exactly like an abort.
                st_d[slot_q]  = ST_IDLE;
                rnd_d[slot_q] = 4'd0;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            slot_q <= '0;
            done_q <= '0;
            for (int c = 0; c < N; c++) begin
                st_q[c]  <= ST_IDLE;
                rnd_q[c] <= 4'd0;
            end
        end else begin
            slot_q <= slot_d;
            done_q <= done_d;
            for (int c = 0; c < N; c++) begin
                st_q[c]  <= st_d[c];
                rnd_q[c] <= rnd_d[c];
            end
        end
    end

`ifdef KS_SCHED_STATS_EN
    logic [15:0] cnt_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q <= 16'd0;
        end else if (rk_last) begin
            cnt_q <= cnt_q + 16'd1;
        end
    end

    assign sched_cnt = cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ks_round_sched.sv
//==============================================================================
// Module  : tb_ks_round_sched
// Brief   : Self-checking bench for ks_round_sched (N=4): vector table, timing
//           model feeding a scoreboard queue, and directed corner sequences.
// Revision: 1.0
//==============================================================================
`default_nettype none

module tb_ks_round_sched;

    typedef struct packed {
        logic [3:0] ack;
        logic [3:0] rnd;
        logic       ena;
        logic [1:0] slot;
        logic [1:0] ksel;
        logic       valid;
        logic       last;
        logic [3:0] busy;
        logic [3:0] done;
    } exp_t;

    typedef struct {
        logic [3:0] st;
        logic [3:0] ab;
        exp_t       e;
    } vec_t;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic [3:0] start = '0;
    logic [3:0] abort = '0;
    logic [3:0] start_ack;
    logic [3:0] rnd_no;
    logic       ena_ks;
    logic [1:0] key_sel;
    logic [1:0] slot_id;
    logic       rk_valid;
    logic       rk_last;
    logic [3:0] ch_busy;
    logic [3:0] ch_done;
`ifdef KS_SCHED_STATS_EN
    logic [15:0] sched_cnt;
`endif

    ks_round_sched #(.N(4)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .start     (start),
        .abort     (abort),
        .start_ack (start_ack),
        .rnd_no    (rnd_no),
        .ena_ks    (ena_ks),
        .key_sel   (key_sel),
        .slot_id   (slot_id),
        .rk_valid  (rk_valid),
        .rk_last   (rk_last),
        .ch_busy   (ch_busy),
        .ch_done   (ch_done)
`ifdef KS_SCHED_STATS_EN
        ,
        .sched_cnt (sched_cnt)
`endif
    );

    always #5 clk = ~clk;

    exp_t w_act;
    assign w_act = {start_ack, rnd_no, ena_ks, slot_id, key_sel, rk_valid, rk_last, ch_busy, ch_done};

    int   n_cmp = 0;
    int   n_err = 0;
    exp_t sb_q[$];

    // Reference model: round number follows from elapsed time since acceptance.
    logic [3:0] m_run;
    int         m_acc [4];
    int         m_done_at [4];
    int         m_t;
    int         m_cnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s @%0t: actual %h required %h", name, $time, act, req);
        end
    endtask

    function automatic exp_t mk(logic [3:0] ack, logic [3:0] rnd, logic ena, logic [1:0] slot,
                                logic v, logic l, logic [3:0] busy, logic [3:0] done);
        exp_t e;
        e.ack = ack; e.rnd = rnd; e.ena = ena; e.slot = slot; e.ksel = slot;
        e.valid = v; e.last = l; e.busy = busy; e.done = done;
        return e;
    endfunction

    task automatic model_reset();
        m_run = '0;
        m_t   = 0;
        m_cnt = 0;
        for (int c = 0; c < 4; c++) begin
            m_acc[c]     = 0;
            m_done_at[c] = -1;
        end
    endtask

    task automatic model_step(input logic [3:0] st, input logic [3:0] ab, output exp_t e);
        int s;
        int r;
        logic [3:0] nrun;
        s = m_t % 4;
        e = '0;
        e.slot = 2'(s);
        e.ksel = 2'(s);
        nrun = m_run;
        for (int c = 0; c < 4; c++) begin
            e.busy[c] = m_run[c];
            e.done[c] = (m_done_at[c] == m_t);
        end
        if (!ab[s]) begin
            if (!m_run[s] && st[s]) begin
                e.ack[s] = 1'b1; e.ena = 1'b1; e.valid = 1'b1;
                nrun[s] = 1'b1;
                m_acc[s] = m_t;
            end else if (m_run[s]) begin
                r = (m_t - m_acc[s]) / 4;
                e.rnd = 4'(r); e.ena = 1'b1; e.valid = 1'b1;
                if (r == 10) begin
                    e.last = 1'b1;
                    nrun[s] = 1'b0;
                    m_done_at[s] = m_t + 1;
                    m_cnt++;
                end
            end
        end
        m_run = nrun & ~ab;
        m_t++;
    endtask

    task automatic apply(input logic [3:0] st, input logic [3:0] ab, input exp_t e,
                         input string name, output exp_t act);
        exp_t got;
        start = st;
        abort = ab;
        sb_q.push_back(e);
        @(negedge clk);
        act = w_act;
        if (sb_q.size() == 0) begin
            got = '0;
            chk("scoreboard_empty", 32'(1), 32'(0));
        end else begin
            got = sb_q.pop_front();
        end
        chk(name, 32'(act), 32'(got));
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rstn  = 1'b0;
        start = '1;
        abort = '0;
        @(negedge clk);
        chk("reset_hold", 32'(w_act), 32'(0));
        @(posedge clk);
        @(posedge clk);
        #1;
        rstn  = 1'b1;
        start = '0;
        model_reset();
    endtask

    task automatic run_phase(input int phase, input int ncyc, input bit hold,
                             input logic [3:0] req_init, input int ab_ch, input int ab_t);
        logic [3:0] req;
        logic [3:0] ab;
        exp_t e;
        exp_t act;
        req = req_init;
        for (int t = 0; t < ncyc; t++) begin
            ab = '0;
            if (t == ab_t) ab[ab_ch] = 1'b1;
            model_step(req, ab, e);
            apply(req, ab, e, "model", act);
            if (!hold) req = req & ~e.ack;
            case (phase)
                3: begin
                    if (t == 2)  chk("p3_ack", 32'(act.ack), 32'(4'b0100));
                    if (t == 3)  chk("p3_busy_rise", 32'(act.busy), 32'(4'b0100));
                    if (t == 42) chk("p3_last", 32'({act.last, act.valid, act.rnd, act.busy}), 32'({2'b11, 4'd10, 4'b0100}));
                    if (t == 43) chk("p3_done", 32'({act.done, act.busy}), 32'({4'b0100, 4'b0000}));
                end
                4: begin
                    if (t >= 40 && t <= 43) chk("p4_last", 32'({act.last, act.rnd, act.slot}), 32'({1'b1, 4'd10, 2'(t - 40)}));
                    if (t >= 44 && t <= 47) chk("p4_restart", 32'({act.ack, act.rnd}), 32'({4'(1 << (t - 44)), 4'd0}));
                end
                5: begin
                    if (t == 15) chk("p5_busy1", 32'(act.busy), 32'(4'b1101));
                    if (t > 14 && (t % 4) == 1) chk("p5_no_valid", 32'(act.valid), 32'(0));
                    if (t == 42) chk("p5_no_done1", 32'(act.done), 32'(0));
                end
                6: begin
                    if (t < 4) chk("p6_restart", 32'({act.ack, act.rnd, act.valid}), 32'({4'(1 << t), 4'd0, 1'b1}));
                end
                default: ;
            endcase
        end
    endtask

    vec_t vec [11];

    initial begin
        exp_t act;

        vec[0]  = '{st: 4'h0, ab: 4'h0, e: mk(4'h0, 4'd0, 1'b0, 2'd0, 1'b0, 1'b0, 4'h0, 4'h0)};
        vec[1]  = '{st: 4'h1, ab: 4'h0, e: mk(4'h0, 4'd0, 1'b0, 2'd1, 1'b0, 1'b0, 4'h0, 4'h0)};
        vec[2]  = '{st: 4'h4, ab: 4'h0, e: mk(4'h4, 4'd0, 1'b1, 2'd2, 1'b1, 1'b0, 4'h0, 4'h0)};
        vec[3]  = '{st: 4'h0, ab: 4'h0, e: mk(4'h0, 4'd0, 1'b0, 2'd3, 1'b0, 1'b0, 4'h4, 4'h0)};
        vec[4]  = '{st: 4'h1, ab: 4'h1, e: mk(4'h0, 4'd0, 1'b0, 2'd0, 1'b0, 1'b0, 4'h4, 4'h0)};
        vec[5]  = '{st: 4'h0, ab: 4'h0, e: mk(4'h0, 4'd0, 1'b0, 2'd1, 1'b0, 1'b0, 4'h4, 4'h0)};
        vec[6]  = '{st: 4'h0, ab: 4'h0, e: mk(4'h0, 4'd1, 1'b1, 2'd2, 1'b1, 1'b0, 4'h4, 4'h0)};
        vec[7]  = '{st: 4'h0, ab: 4'h4, e: mk(4'h0, 4'd0, 1'b0, 2'd3, 1'b0, 1'b0, 4'h4, 4'h0)};
        vec[8]  = '{st: 4'h0, ab: 4'h0, e: mk(4'h0, 4'd0, 1'b0, 2'd0, 1'b0, 1'b0, 4'h0, 4'h0)};
        vec[9]  = '{st: 4'h4, ab: 4'h0, e: mk(4'h0, 4'd0, 1'b0, 2'd1, 1'b0, 1'b0, 4'h0, 4'h0)};
        vec[10] = '{st: 4'h4, ab: 4'h0, e: mk(4'h4, 4'd0, 1'b1, 2'd2, 1'b1, 1'b0, 4'h0, 4'h0)};

        do_reset();
        for (int i = 0; i < 11; i++) begin
            apply(vec[i].st, vec[i].ab, vec[i].e, "table", act);
        end

        do_reset();
        run_phase(1, 40, 1'b0, 4'h0, 0, -1);

        do_reset();
        run_phase(3, 50, 1'b0, 4'b0100, 0, -1);

        do_reset();
        run_phase(4, 52, 1'b1, 4'hF, 0, -1);

        do_reset();
        run_phase(5, 50, 1'b0, 4'hF, 1, 14);
`ifdef KS_SCHED_STATS_EN
        chk("sched_cnt", 32'(sched_cnt), 32'(16'd3));
`endif

        do_reset();
        run_phase(0, 20, 1'b1, 4'hF, 0, -1);
        start = 4'hF;
        rstn  = 1'b0;
        #1;
        chk("async_reset", 32'(w_act), 32'(0));
        do_reset();
        run_phase(6, 12, 1'b1, 4'hF, 0, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual timeout required completion");
        $fatal(1, "bench timeout");
    end

endmodule

`default_nettype wire

// File: doc/ks_round_sched.md
# ks_round_sched

Round sequencer for the N-channel time-interleaved AES key schedule. A slot counter visits channels 0..N-1 in strict rotation, one per clock, matching the key schedule's N-deep key pipeline. For each busy channel the block drives the round number (0..10) and the key-schedule enable, selects that channel's cipher key for loading, and tags each emitted round key with channel id, valid and last flags. It accepts per-channel start requests, supports per-channel abort, and reports per-channel completion.

## Interface
- `N`, 4: number of interleaved channels, 1..16; must equal the key schedule's `N`.
- `CW`, `(N>1)?$clog2(N):1`: channel-id width (derived; not overridden).
- `clk`  in  1  clock; all state on rising edge.
- `rstn`  in  1  asynchronous active-low reset.
- `start`  in  N  per-channel level request; held until `start_ack`.
- `abort`  in  N  per-channel abort pulse or level.
- `start_ack`  out  N  one-hot, combinational; request accepted this cycle.
- `rnd_no`  out  4  round number to key schedule `rndNo`.
- `ena_ks`  out  1  to key schedule `enaKS`.
- `key_sel`  out  CW  channel whose cipher key the top muxes onto `ip_key` (equals `slot_id`).
- `slot_id`  out  CW  channel owning the current cycle.
- `rk_valid`  out  1  key-schedule `op_key` this cycle is a real round key of `slot_id`.
- `rk_last`  out  1  with `rk_valid`: round-10 key.
- `ch_busy`  out  N  channel in RUN.
- `ch_done`  out  N  one-cycle registered pulse after round 10 issued.

## Operation
- Registered state: `slot` (CW bits), per channel `st[c]` ∈ {IDLE, RUN}, `rnd[c]` (4 bits), `done_q` (N bits).
- `slot` increments every cycle, wraps N-1→0; never stalls (key pipeline shifts every cycle). N=1: `slot` fixed 0.
- Current slot s, channel c=s, decode priority:
  - `abort[c]`: `rnd_no`=0, `ena_ks`=0, `rk_valid`=0, no ack; next `st[c]`=IDLE, `rnd[c]`=0.
  - IDLE and `start[c]`: `start_ack[c]`=1, `rnd_no`=0, `ena_ks`=1, `rk_valid`=1 (round-0 key = cipher key); next RUN, `rnd[c]`=1.
  - IDLE, no start: `rnd_no`=0, `ena_ks`=0, `rk_valid`=0.
  - RUN: `rnd_no`=`rnd[c]`, `ena_ks`=1, `rk_valid`=1; if `rnd[c]`==10: `rk_last`=1, next IDLE, `rnd[c]`=0, `done_q[c]` set; else `rnd[c]`+1.
- `abort[c]` in a non-owned cycle: next `st[c]`=IDLE, `rnd[c]`=0, no `ch_done`.
- `start[c]` seen only in slot c; a channel finishing round 10 can restart no earlier than its next slot (N cycles later).
- `rnd[c]` never exceeds 10; values 11..15 unreachable; if corrupted, RUN with `rnd`>10 → treated as abort.
- `ch_busy[c]` = (`st[c]`==RUN); `ch_done` = `done_q`, cleared every cycle otherwise.

## Timing
- Reset: `slot`=0, all IDLE, `rnd`=0, `done_q`=0 → `rnd_no`=0, `ena_ks`=0, `rk_valid`=0, `rk_last`=0, `ch_busy`=0, `ch_done`=0, `slot_id`=`key_sel`=0; `start_ack` gated by `rstn`, forced 0 during reset.
- All outputs except `start_ack` decode from registers only; `start_ack` combinational from `start`, `abort`, state.
- Accept at cycle t → round r key at t+r·N (r=0..10), `rk_last` at t+10N, `ch_done` at t+10N+1, `ch_busy` high t+1..t+10N.
- Reset mid-schedule: all channels IDLE immediately, no `ch_done`.

## Configuration
- `KS_SCHED_STATS_EN` defined: adds output `sched_cnt` [15:0], count of completed schedules (all channels), reset 0, +1 per round-10 issue, wraps 0xFFFF→0; aborted schedules not counted.
- Undefined: port and counter absent; behaviour otherwise identical.

## Test plan
- Reset, N=4, no start: 40 cycles `slot_id` 0,1,2,3,0…, `ena_ks`=0, `rk_valid`=0, all outputs 0.
- `start[2]` held from cycle 0: ack at cycle 2, `rnd_no` 0,1,…,10 at cycles 2,6,…,42, `rk_last` at 42, `ch_done[2]` at 43, `ch_busy[2]` cycles 3..42; FIPS-197 key 2b7e1516… gives round-10 key d014f9a8c9ee2589e13f0cc8b6630ca6.
- All four `start` held from reset: interleaved round keys every cycle, each channel's round-10 key at cycles 40..43, restart acks at 44..47.
- `abort[1]` at cycle 14 mid-run (started cycle 1): `ch_busy[1]` low at 15, no `rk_valid` in slot 1 thereafter, no `ch_done[1]`; channels 0,2,3 unaffected.
- `abort[0]` and `start[0]` together in slot 0: no ack, channel stays IDLE; `rstn` low at cycle 20 of a run: all outputs 0 asynchronously, restart acks at round 0.
- `KS_SCHED_STATS_EN`: 3 completed plus 1 aborted schedule → `sched_cnt`=3.
